// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: register file geometry, stall causes and the
// per-slot request bundle used by the superscalar scoreboard.
package lc4_pkg;
  localparam int REG_W    = 3;
  localparam int NUM_REGS = 8;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_RAW,
    CAUSE_WAW,
    CAUSE_LOAD_PORT,
    CAUSE_FLUSH
  } stall_cause_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    logic     rs_re;
    logic     rt_re;
    logic     rd_we;
    logic     is_load;
  } slot_req_t;

  // One-hot register mask, empty when the field is not enabled.
  function automatic logic [NUM_REGS-1:0] reg_mask(input reg_idx_t r, input logic en);
    return en ? (NUM_REGS'(1) << r) : '0;
  endfunction
endpackage

// File: rtl/lc4_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset and enable.
module lc4_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (en && count != '1)  count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/lc4_ss_scoreboard.sv
// Dual-issue register scoreboard: tracks pending writes per register and
// decides which of the two presented slots may issue this cycle.
module lc4_ss_scoreboard
  import lc4_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             i_valid_A,
  input  logic             i_valid_B,
  input  logic [2:0]       i_rs_A,
  input  logic [2:0]       i_rt_A,
  input  logic [2:0]       i_rd_A,
  input  logic [2:0]       i_rs_B,
  input  logic [2:0]       i_rt_B,
  input  logic [2:0]       i_rd_B,
  input  logic             i_rs_re_A,
  input  logic             i_rt_re_A,
  input  logic             i_rd_we_A,
  input  logic             i_is_load_A,
  input  logic             i_rs_re_B,
  input  logic             i_rt_re_B,
  input  logic             i_rd_we_B,
  input  logic             i_is_load_B,
  input  logic [2:0]       i_wb_rd_A,
  input  logic [2:0]       i_wb_rd_B,
  input  logic             i_wb_we_A,
  input  logic             i_wb_we_B,
  input  logic             i_flush,
  output logic             o_issue_A,
  output logic             o_issue_B,
  output logic [7:0]       o_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_split_cnt
);
  slot_req_t [1:0]     slot;
  logic [NUM_REGS-1:0] busy, wb_clr, eff_busy, busy_set;
  logic [1:0]          src_hit, dst_hit;
  logic                intra_raw, intra_waw, both_load;
  stall_cause_e        cause_a, cause_b;

  assign slot[0] = '{valid: i_valid_A, rs: i_rs_A, rt: i_rt_A, rd: i_rd_A,
                     rs_re: i_rs_re_A, rt_re: i_rt_re_A, rd_we: i_rd_we_A, is_load: i_is_load_A};
  assign slot[1] = '{valid: i_valid_B, rs: i_rs_B, rt: i_rt_B, rd: i_rd_B,
                     rs_re: i_rs_re_B, rt_re: i_rt_re_B, rd_we: i_rd_we_B, is_load: i_is_load_B};

  // Same-cycle writebacks are bypassed by the regfile, so they no longer block.
  assign wb_clr   = reg_mask(i_wb_rd_A, i_wb_we_A) | reg_mask(i_wb_rd_B, i_wb_we_B);
  assign eff_busy = busy & ~wb_clr;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign src_hit[s] = |(eff_busy & (reg_mask(slot[s].rs, slot[s].rs_re) |
                                      reg_mask(slot[s].rt, slot[s].rt_re)));
    assign dst_hit[s] = |(eff_busy & reg_mask(slot[s].rd, slot[s].rd_we));
  end

  assign intra_raw = slot[0].rd_we &
                     ((slot[1].rs_re & (slot[1].rs == slot[0].rd)) |
                      (slot[1].rt_re & (slot[1].rt == slot[0].rd)));
  assign intra_waw = slot[0].rd_we & slot[1].rd_we & (slot[1].rd == slot[0].rd);
  assign both_load = slot[0].is_load & slot[1].is_load;

  always_comb begin
    cause_a = CAUSE_NONE;
    if (i_flush)         cause_a = CAUSE_FLUSH;
    else if (src_hit[0]) cause_a = CAUSE_RAW;
    else if (dst_hit[0]) cause_a = CAUSE_WAW;
  end

  always_comb begin
    cause_b = CAUSE_NONE;
    if (i_flush)                      cause_b = CAUSE_FLUSH;
    else if (src_hit[1] || intra_raw) cause_b = CAUSE_RAW;
    else if (dst_hit[1] || intra_waw) cause_b = CAUSE_WAW;
    else if (both_load)               cause_b = CAUSE_LOAD_PORT;
  end

  assign o_issue_A = ~rst & slot[0].valid & (cause_a == CAUSE_NONE);
  assign o_issue_B = o_issue_A & slot[1].valid & (cause_b == CAUSE_NONE);

  assign busy_set = reg_mask(slot[0].rd, o_issue_A & slot[0].rd_we) |
                    reg_mask(slot[1].rd, o_issue_B & slot[1].rd_we);

  // Set is applied after clear so an issuing writer keeps its register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            busy <= '0;
    else if (gwe) begin
      if (i_flush)      busy <= '0;
      else              busy <= (busy & ~wb_clr) | busy_set;
    end
  end

  assign o_busy = busy;

  lc4_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (gwe & i_valid_A & ~o_issue_A & ~i_flush),
    .count (o_stall_cnt)
  );

  lc4_sat_counter #(.CNT_W(CNT_W)) u_split_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (gwe & o_issue_A & i_valid_B & ~o_issue_B),
    .count (o_split_cnt)
  );
endmodule
